register_bank: RTL and testbench
================================

REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  clock; all register writes occur on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset; clears the register file.
REQ-004 RA  input  5  register address for operand A read port.
REQ-005 RB  input  5  register address for operand B read port.
REQ-006 RW_dm  input  5  write address; register written with ans_dm.
REQ-007 ans_dm  input  16  write data, and forwarding source for select code 10.
REQ-008 ans_ex  input  16  forwarding source for select code 01.
REQ-009 ans_wb  input  16  forwarding source for select code 11.
REQ-010 imm  input  16  immediate operand for B.
REQ-011 mux_sel_A  input  2  operand A source select.
REQ-012 mux_sel_B  input  2  operand B source select.
REQ-013 imm_sel  input  1  1 = B takes imm; 0 = B takes the mux_sel_B result.
REQ-014 A  output  16  operand A, combinational.
REQ-015 B  output  16  operand B, combinational.

Function
REQ-016 Storage SHALL be 32 registers of 16 bits, addresses 0-31.
- Register 0 is an ordinary writable register; it is not hardwired to zero.
REQ-017 On every rising clk edge with rst_n high, register[RW_dm] SHALL load ans_dm.
- There is no write enable; a write happens every cycle.
REQ-018 Register reads SHALL be combinational.
- A read of the address being written in the same cycle returns the old value until the clock edge.
- The register file has no internal bypass; forwarding is done only through the select muxes.
REQ-019 A SHALL be selected by mux_sel_A:
- 00 = register[RA]
- 01 = ans_ex
- 10 = ans_dm
- 11 = ans_wb
REQ-020 The pre-immediate B value SHALL be selected by mux_sel_B using the same encoding, with register[RB] for code 00.
REQ-021 When imm_sel=1, B SHALL equal imm regardless of mux_sel_B; when imm_sel=0, B SHALL equal the mux_sel_B result.
REQ-022 A and B SHALL update in the same cycle as any change to RA, RB, selects, imm_sel or data inputs (zero latency).
- After a write, register contents are visible on A and B immediately following the clock edge.
REQ-023 RA and RB SHALL be allowed to be equal, or equal to RW_dm; each port reads independently.
REQ-024 Data SHALL pass through unmodified; there is no arithmetic, sign extension or truncation, and all paths are 16 bits wide.

Reset
REQ-025 While rst_n=0, all 32 registers SHALL be 0x0000 and writes SHALL be suppressed, regardless of clk.
REQ-026 Assertion of rst_n SHALL take effect immediately (asynchronous); deassertion SHALL be sampled so that the first write occurs on the first rising edge after rst_n goes high.
REQ-027 A and B SHALL have no reset state of their own.
- During reset they follow the muxes, so select code 00 yields 0x0000.
- Forwarded or immediate sources still pass through during reset.
REQ-028 Reset asserted mid-operation SHALL clear all registers, including any write occurring in the same cycle.

Verification
REQ-029 Reset: rst_n=0, mux_sel_A=00, mux_sel_B=00, imm_sel=1, imm=0xFFFF, RA=5 -> A=0x0000, B=0xFFFF.
REQ-030 Write/read: rst_n=1, RW_dm=7, ans_dm=0xD000, one rising edge, then RA=7, RB=7, selects 00, imm_sel=0 -> A=0xD000, B=0xD000.
- Register 5 remains 0x0000.
REQ-031 Forwarding: ans_ex=0xC000, ans_dm=0xD000, ans_wb=0xE000, mux_sel_A=10, mux_sel_B=01, imm_sel=0 -> A=0xD000, B=0xC000.
- Then mux_sel_A=11, mux_sel_B=00, RB=6 with register 6 = 0 -> A=0xE000, B=0x0000.
REQ-032 Immediate override: imm_sel=1, imm=0x1234, each mux_sel_B value 00-11 -> B=0x1234 in all four cases.
REQ-033 Read-during-write: register 3=0x0001, RA=3, RW_dm=3, ans_dm=0x00AA -> A=0x0001 before the edge, A=0x00AA after it.
REQ-034 Async reset mid-run: registers loaded, rst_n pulsed low between clock edges -> all 32 registers read 0x0000 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/register_bank.sv
`timescale 1ns/1ps
// 32 x 16-bit register file, written every cycle from ans_dm, with
// forwarding muxes on both operand ports and an immediate override on B.
module register_bank (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  RA,
  input  logic [4:0]  RB,
  input  logic [4:0]  RW_dm,
  input  logic [15:0] ans_dm,
  input  logic [15:0] ans_ex,
  input  logic [15:0] ans_wb,
  input  logic [15:0] imm,
  input  logic [1:0]  mux_sel_A,
  input  logic [1:0]  mux_sel_B,
  input  logic        imm_sel,
  output logic [15:0] A,
  output logic [15:0] B
);

  logic [15:0] regs [32];
  logic [15:0] rd_a;
  logic [15:0] rd_b;
  logic [15:0] fwd_b;

  // No write enable: the pipeline always retires something into RW_dm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else begin
      regs[RW_dm] <= ans_dm;
    end
  end

  // Reads see the pre-edge contents; bypassing happens only via the selects.
  assign rd_a = regs[RA];
  assign rd_b = regs[RB];

  always_comb begin
    A = rd_a;
    case (mux_sel_A)
      2'b00: A = rd_a;
      2'b01: A = ans_ex;
      2'b10: A = ans_dm;
      2'b11: A = ans_wb;
      default: A = rd_a;
    endcase
  end

  always_comb begin
    fwd_b = rd_b;
    case (mux_sel_B)
      2'b00: fwd_b = rd_b;
      2'b01: fwd_b = ans_ex;
      2'b10: fwd_b = ans_dm;
      2'b11: fwd_b = ans_wb;
      default: fwd_b = rd_b;
    endcase
  end

  assign B = imm_sel ? imm : fwd_b;

endmodule

// File: tb/tb_register_bank.sv
`timescale 1ns/1ps
// Directed bench for register_bank: vector table plus hand-written
// sequences for write timing, read-during-write and asynchronous reset.
module tb_register_bank;

  logic        clk;
  logic        rst_n;
  logic [4:0]  RA, RB, RW_dm;
  logic [15:0] ans_dm, ans_ex, ans_wb, imm;
  logic [1:0]  mux_sel_A, mux_sel_B;
  logic        imm_sel;
  logic [15:0] A, B;

  int n_total = 0;
  int n_pass  = 0;
  logic [15:0] model [32];

  typedef struct {
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic        isel;
    logic [15:0] ex;
    logic [15:0] dm;
    logic [15:0] wb;
    logic [15:0] im;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs [9];

  register_bank dut (
    .clk(clk), .rst_n(rst_n), .RA(RA), .RB(RB), .RW_dm(RW_dm),
    .ans_dm(ans_dm), .ans_ex(ans_ex), .ans_wb(ans_wb), .imm(imm),
    .mux_sel_A(mux_sel_A), .mux_sel_B(mux_sel_B), .imm_sel(imm_sel),
    .A(A), .B(B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 ns");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Write one register on the next rising edge, then park writes on reg 31.
  task automatic wr(input logic [4:0] addr, input logic [15:0] data);
    @(negedge clk);
    RW_dm  = addr;
    ans_dm = data;
    @(posedge clk);
    #1;
    model[addr] = data;
    RW_dm = 5'd31;
  endtask

  initial begin
    // ra rb sa sb isel ex dm wb imm | A B  (reg i = 0x1000 + i*0x0111)
    vecs[0] = '{5'd0,  5'd1,  2'd0, 2'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1000, 16'h1111};
    vecs[1] = '{5'd30, 5'd16, 2'd0, 2'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h2FFE, 16'h2110};
    vecs[2] = '{5'd5,  5'd5,  2'd0, 2'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1555, 16'h1555};
    vecs[3] = '{5'd21, 5'd15, 2'd1, 2'd0, 1'b0, 16'hAAAA, 16'h0000, 16'h0000, 16'h0000, 16'hAAAA, 16'h1FFF};
    vecs[4] = '{5'd0,  5'd0,  2'd2, 2'd3, 1'b0, 16'h0000, 16'h5555, 16'h3C3C, 16'h0000, 16'h5555, 16'h3C3C};
    vecs[5] = '{5'd0,  5'd0,  2'd3, 2'd2, 1'b0, 16'h0000, 16'hF0F0, 16'h0F0F, 16'h0000, 16'h0F0F, 16'hF0F0};
    vecs[6] = '{5'd1,  5'd30, 2'd0, 2'd0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h8001, 16'h1111, 16'h8001};
    vecs[7] = '{5'd16, 5'd5,  2'd1, 2'd1, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
    vecs[8] = '{5'd21, 5'd21, 2'd0, 2'd3, 1'b1, 16'h0000, 16'h0000, 16'h1111, 16'h0000, 16'h2665, 16'h0000};

    for (int i = 0; i < 32; i++) model[i] = 16'h0000;

    // Reset state; writes to reg 5 must be suppressed while held in reset.
    rst_n = 1'b0; RA = 5'd5; RB = 5'd5; RW_dm = 5'd5;
    ans_dm = 16'hBEEF; ans_ex = 16'h0000; ans_wb = 16'h0000;
    imm = 16'hFFFF; mux_sel_A = 2'b00; mux_sel_B = 2'b00; imm_sel = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_A", A, 16'h0000);
    chk("reset_B_imm", B, 16'hFFFF);

    @(negedge clk);
    rst_n = 1'b1;
    RW_dm = 5'd31;

    // Write then read back on both ports
    wr(5'd7, 16'hD000);
    RA = 5'd7; RB = 5'd7; mux_sel_A = 2'b00; mux_sel_B = 2'b00; imm_sel = 1'b0;
    #1;
    chk("wr7_A", A, 16'hD000);
    chk("wr7_B", B, 16'hD000);
    RA = 5'd5;
    #1;
    chk("reg5_untouched", A, 16'h0000);

    // Forwarding
    ans_ex = 16'hC000; ans_dm = 16'hD000; ans_wb = 16'hE000;
    mux_sel_A = 2'b10; mux_sel_B = 2'b01;
    #1;
    chk("fwd_A_dm", A, 16'hD000);
    chk("fwd_B_ex", B, 16'hC000);
    mux_sel_A = 2'b11; mux_sel_B = 2'b00; RB = 5'd6;
    #1;
    chk("fwd_A_wb", A, 16'hE000);
    chk("reg6_B", B, 16'h0000);

    // Immediate overrides every B select
    imm_sel = 1'b1; imm = 16'h1234;
    for (int s = 0; s < 4; s++) begin
      mux_sel_B = 2'(s);
      #1;
      chk($sformatf("imm_sel_B%0d", s), B, 16'h1234);
    end
    imm_sel = 1'b0;

    // Read-during-write returns old value until the edge
    wr(5'd3, 16'h0001);
    @(negedge clk);
    RA = 5'd3; mux_sel_A = 2'b00; RW_dm = 5'd3; ans_dm = 16'h00AA;
    #1;
    chk("rdw_before_edge", A, 16'h0001);
    @(posedge clk);
    #1;
    chk("rdw_after_edge", A, 16'h00AA);
    RW_dm = 5'd31;

    // Fill registers 0..30 and read them all back on both ports
    for (int i = 0; i < 31; i++) wr(5'(i), 16'h1000 + 16'(i) * 16'h0111);
    mux_sel_A = 2'b00; mux_sel_B = 2'b00; imm_sel = 1'b0;
    for (int i = 0; i < 31; i++) begin
      RA = 5'(i); RB = 5'(30 - i);
      #0.2;
      chk($sformatf("rd_A_r%0d", i), A, model[i]);
      chk($sformatf("rd_B_r%0d", 30 - i), B, model[30 - i]);
    end

    // Vector table
    for (int v = 0; v < 9; v++) begin
      RA = vecs[v].ra; RB = vecs[v].rb;
      mux_sel_A = vecs[v].sa; mux_sel_B = vecs[v].sb; imm_sel = vecs[v].isel;
      ans_ex = vecs[v].ex; ans_dm = vecs[v].dm; ans_wb = vecs[v].wb; imm = vecs[v].im;
      #1;
      chk($sformatf("vec%0d_A", v), A, vecs[v].exp_a);
      chk($sformatf("vec%0d_B", v), B, vecs[v].exp_b);
    end

    // Asynchronous reset between edges clears everything at once
    @(negedge clk);
    #0.5;
    mux_sel_A = 2'b00; mux_sel_B = 2'b00; imm_sel = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) begin
      RA = 5'(i); RB = 5'(31 - i);
      #0.1;
      chk($sformatf("async_clr_A_r%0d", i), A, 16'h0000);
      chk($sformatf("async_clr_B_r%0d", 31 - i), B, 16'h0000);
    end

    // Forwarded and immediate paths still pass during reset
    mux_sel_A = 2'b01; ans_ex = 16'h7E7E; imm_sel = 1'b1; imm = 16'h4242;
    #0.2;
    chk("rst_fwd_A", A, 16'h7E7E);
    chk("rst_imm_B", B, 16'h4242);

    // First write lands on the first rising edge after release
    @(negedge clk);
    rst_n = 1'b1; RW_dm = 5'd9; ans_dm = 16'h5A5A;
    RA = 5'd9; mux_sel_A = 2'b00; imm_sel = 1'b0;
    #1;
    chk("post_rst_before_edge", A, 16'h0000);
    @(posedge clk);
    #1;
    chk("post_rst_first_write", A, 16'h5A5A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
